rob_alloc_ctrl: RTL
===================

// Module: rob_alloc_ctrl
// PURPOSE
//  Allocation/occupancy controller for the reorder buffer. Hands out ROB entry addresses
//  to up to two dispatching instructions per cycle and tracks head/tail/occupancy as
//  entries commit. Blocks dispatch on insufficient space and squashes all uncommitted
//  entries on a pipeline flush. Sits between the dispatch stage and the ROB write ports.
// PARAMETERS
//  ROB_NUM   64   number of ROB entries; power of two, >= 4
//  ROB_SEL   6    log2(ROB_NUM); width of ROB entry addresses
// PORTS
//  clk           in   1          clock
//  reset         in   1          synchronous, active-high reset
//  req_num_i     in   2          instructions requesting dispatch this cycle (0..2; 3 is treated as 2)
//  commit_num_i  in   2          entries retired by the ROB this cycle (0..2)
//  flush_i       in   1          squash every uncommitted entry
//  dp1_o         out  1          write enable for ROB slot at dp1_addr_o
//  dp2_o         out  1          write enable for ROB slot at dp2_addr_o
//  dp1_addr_o    out  ROB_SEL    tail pointer
//  dp2_addr_o    out  ROB_SEL    (tail+1) mod ROB_NUM
//  stall_o       out  1          dispatch request refused this cycle
//  head_o        out  ROB_SEL    oldest live entry (commit pointer mirror)
//  count_o       out  ROB_SEL+1  live entry count, 0..ROB_NUM
//  full_o        out  1          count_o == ROB_NUM
//  empty_o       out  1          count_o == 0
// BEHAVIOUR
//  - State registers: head, tail (ROB_SEL bits, wrap mod ROB_NUM), count (ROB_SEL+1 bits),
//    FSM {RUN, RECOVER}. Reset: head=tail=count=0, state=RUN.
//  - Output values after reset: dp1_o=dp2_o=0, stall_o=0, full_o=0, empty_o=1.
//    Addresses are 0 and 1.
//  - free = ROB_NUM - count, using the registered count only. A commit in the same cycle
//    does not create space for that cycle's dispatch.
//  - grant (combinational): state==RUN && !flush_i && req_n>0 && req_n<=free;
//    req_n = min(req_num_i,2).
//  - dp1_o = grant; dp2_o = grant && req_n==2. Allocation is all-or-nothing: no partial
//    grant of one out of two.
//  - stall_o = req_n>0 && !grant (this includes RECOVER and flush cycles).
//  - commit_n = min(commit_num_i, count). Over-commit is a protocol error and is clamped,
//    never underflowing.
//  - Update when flush_i=0: head += commit_n; tail += alloc_n;
//    count <= count + alloc_n - commit_n, where alloc_n = grant ? req_n : 0.
//  - flush_i=1 (priority over dispatch): commit_n is still applied to head;
//    tail <= head + commit_n; count <= 0; state <= RECOVER.
//  - RECOVER lasts exactly one cycle: grant is forced to 0, commits are still accepted,
//    then state <= RUN. A flush during RECOVER re-enters RECOVER.
//  - Wrap: pointers roll from ROB_NUM-1 to 0. With tail=ROB_NUM-1, dp2_addr_o=0.
//  - Full: count==ROB_NUM means tail==head; full_o=1 and any request stalls.
//  - Outputs dp*, stall_o are combinational from state and inputs.
//    head_o, count_o, full_o, empty_o are registered-state derived.
//  - reset mid-operation: all state returns to reset values on the next edge regardless of
//    other inputs. The ROB entry contents are not cleared by this block.
// TESTING
//  1. Reset, then req=2 for 32 cycles (ROB_NUM=64), no commits -> addresses (0,1),(2,3),...;
//     count=64, full_o=1; 33rd req=2 -> stall_o=1, dp1_o=0.
//  2. count=63, req=2 -> stall_o=1, no allocation; same cycle req=1 -> dp1_o=1, count=64.
//  3. count=64, req=1 and commit=1 same cycle -> stall_o=1; next cycle count=63,
//     req=1 -> granted.
//  4. tail=63, req=2 -> dp1_addr=63, dp2_addr=0; next tail=1.
//  5. head=10, count=20, commit=2 and flush_i same cycle -> head=12, tail=12, count=0,
//     empty_o=1; next cycle req=1 -> stall_o=1 (RECOVER); following cycle dp1_addr=12.
//  6. Random req/commit/flush over 10k cycles vs reference model:
//     count==(tail-head) mod 64 (64 when full); count never >64 or <0.

Source files
------------

// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/commit handshake between the dispatch stage, the ROB and the ROB allocation controller.
interface rob_alloc_ctrl_if #(
  parameter int unsigned ROB_SEL = 6
);
  logic [1:0]         req_num_i;
  logic [1:0]         commit_num_i;
  logic               flush_i;
  logic               dp1_o;
  logic               dp2_o;
  logic [ROB_SEL-1:0] dp1_addr_o;
  logic [ROB_SEL-1:0] dp2_addr_o;
  logic               stall_o;
  logic [ROB_SEL-1:0] head_o;
  logic [ROB_SEL:0]   count_o;
  logic               full_o;
  logic               empty_o;

  modport master (
    output req_num_i, commit_num_i, flush_i,
    input  dp1_o, dp2_o, dp1_addr_o, dp2_addr_o, stall_o,
    input  head_o, count_o, full_o, empty_o
  );

  modport slave (
    input  req_num_i, commit_num_i, flush_i,
    output dp1_o, dp2_o, dp1_addr_o, dp2_addr_o, stall_o,
    output head_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: hands out up to two entry addresses per cycle,
// tracks head/tail/occupancy across commits, and squashes everything on flush.
module rob_alloc_ctrl #(
  parameter int unsigned ROB_NUM = 64,
  parameter int unsigned ROB_SEL = 6
) (
  input  logic            clk,
  input  logic            reset,
  rob_alloc_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = ROB_SEL + 1;
  localparam logic [CNT_W-1:0] ROB_NUM_C = CNT_W'(ROB_NUM);

  typedef enum logic {
    RUN,
    RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [ROB_SEL-1:0] head_q, head_d;
  logic [ROB_SEL-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [1:0]         req_n_c;
  logic [1:0]         commit_n_c;
  logic [1:0]         alloc_n_c;
  logic [CNT_W-1:0]   free_c;
  logic               grant_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Grant decision and next-state; space is judged on the registered count only
  always_comb begin
    req_n_c    = (bus.req_num_i == 2'd3) ? 2'd2 : bus.req_num_i;
    commit_n_c = (CNT_W'(bus.commit_num_i) > count_q) ? count_q[1:0] : bus.commit_num_i;
    free_c     = ROB_NUM_C - count_q;
    grant_c    = (state_q == RUN) && !bus.flush_i && (req_n_c != 2'd0) &&
                 (CNT_W'(req_n_c) <= free_c);
    alloc_n_c  = grant_c ? req_n_c : 2'd0;

    state_d    = state_q;
    head_d     = head_q + ROB_SEL'(commit_n_c);
    tail_d     = tail_q + ROB_SEL'(alloc_n_c);
    count_d    = count_q + CNT_W'(alloc_n_c) - CNT_W'(commit_n_c);

    case (state_q)
      RUN:     state_d = RUN;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase

    // Flush drops every uncommitted entry; tail snaps to the post-commit head
    if (bus.flush_i) begin
      tail_d  = head_d;
      count_d = '0;
      state_d = RECOVER;
    end
  end

  assign bus.dp1_o      = grant_c;
  assign bus.dp2_o      = grant_c && (req_n_c == 2'd2);
  assign bus.stall_o    = (req_n_c != 2'd0) && !grant_c;
  assign bus.dp1_addr_o = tail_q;
  assign bus.dp2_addr_o = tail_q + ROB_SEL'(1);
  assign bus.head_o     = head_q;
  assign bus.count_o    = count_q;
  assign bus.full_o     = (count_q == ROB_NUM_C);
  assign bus.empty_o    = (count_q == '0);

endmodule
